// File: rtl/window_serializer.sv
// Captures one parallel window per handshake and streams its elements out one per
// strobe, with optional idle gaps between elements, consumer hold and flush.
module window_serializer #(
  parameter int pDATA_W          = 8,
  parameter int pNUM_OF_ELEMENTS = 9,
  parameter int pGAP_CYCLES      = 0
) (
  input  logic                                iclk,
  input  logic                                irst,
  input  logic [pNUM_OF_ELEMENTS*pDATA_W-1:0] iwindow,
  input  logic                                iwindow_valid,
  output logic                                owindow_ready,
  input  logic                                ihold,
  input  logic                                iflush,
  output logic [pDATA_W-1:0]                  odata,
  output logic                                odata_en,
  output logic                                odata_last,
  output logic                                obusy
);
  localparam int IDX_W = $clog2(pNUM_OF_ELEMENTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(pNUM_OF_ELEMENTS - 1);
  localparam logic [3:0] GAP_LAST = 4'((pGAP_CYCLES > 0) ? pGAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [3:0]         gap_cnt_reg;
  logic [pDATA_W-1:0] odata_reg;
  logic               odata_en_reg;
  logic               odata_last_reg;
  logic               obusy_reg;
  logic [pDATA_W-1:0] win_elem [pNUM_OF_ELEMENTS];
  logic [pDATA_W-1:0] buf_reg  [pNUM_OF_ELEMENTS];
  logic               accept;

  generate
    for (genvar gi = 0; gi < pNUM_OF_ELEMENTS; gi++) begin : g_unpack
      assign win_elem[gi] = iwindow[gi*pDATA_W +: pDATA_W];
    end
  endgenerate

  assign owindow_ready = (state_reg == IDLE) && !irst && !iflush;
  assign accept        = iwindow_valid && owindow_ready;

  // The stored copy decouples emission from whatever the producer drives next.
  always_ff @(posedge iclk) begin
    if (accept) begin
      buf_reg <= win_elem;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      gap_cnt_reg    <= '0;
      odata_reg      <= '0;
      odata_en_reg   <= 1'b0;
      odata_last_reg <= 1'b0;
      obusy_reg      <= 1'b0;
    end else if (iflush) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      odata_en_reg   <= 1'b0;
      odata_last_reg <= 1'b0;
      obusy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          odata_en_reg   <= 1'b0;
          odata_last_reg <= 1'b0;
          if (accept) begin
            state_reg <= SEND;
            idx_reg   <= '0;
            obusy_reg <= 1'b1;
          end
        end
        SEND: begin
          if (ihold) begin
            odata_en_reg   <= 1'b0;
            odata_last_reg <= 1'b0;
          end else begin
            odata_reg      <= buf_reg[idx_reg];
            odata_en_reg   <= 1'b1;
            odata_last_reg <= (idx_reg == LAST_IDX);
            if (idx_reg == LAST_IDX) begin
              state_reg <= IDLE;
              idx_reg   <= '0;
              obusy_reg <= 1'b0;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
              if (pGAP_CYCLES > 0) begin
                state_reg   <= GAP;
                gap_cnt_reg <= '0;
              end
            end
          end
        end
        GAP: begin
          // Gap timing is fixed; hold only matters once we are back in SEND.
          odata_en_reg   <= 1'b0;
          odata_last_reg <= 1'b0;
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= SEND;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          obusy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign odata      = odata_reg;
  assign odata_en   = odata_en_reg;
  assign odata_last = odata_last_reg;
  assign obusy      = obusy_reg;

endmodule

// File: tb/tb_window_serializer.sv
// Bench for window_serializer: default instance (N=9, no gap) and a gapped
// instance (N=3, gap=2), checked against an edge-level emission model.
module tb_window_serializer;
  localparam int W  = 8;
  localparam int N  = 9;
  localparam int GN = 3;
  localparam int GG = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           irst  = 1'b1;
  logic [N*W-1:0] win   = '0;
  logic           valid = 1'b0;
  logic           hold  = 1'b0;
  logic           flush = 1'b0;
  logic           ready, en, last, busy;
  logic [W-1:0]   data;

  logic [GN*W-1:0] g_win   = '0;
  logic            g_valid = 1'b0;
  logic            g_hold  = 1'b0;
  logic            g_flush = 1'b0;
  logic            g_ready, g_en, g_last, g_busy;
  logic [W-1:0]    g_data;

  window_serializer #(.pDATA_W(W), .pNUM_OF_ELEMENTS(N), .pGAP_CYCLES(0)) dut (
    .iclk(clk), .irst(irst), .iwindow(win), .iwindow_valid(valid),
    .owindow_ready(ready), .ihold(hold), .iflush(flush),
    .odata(data), .odata_en(en), .odata_last(last), .obusy(busy)
  );

  window_serializer #(.pDATA_W(W), .pNUM_OF_ELEMENTS(GN), .pGAP_CYCLES(GG)) dut_gap (
    .iclk(clk), .irst(irst), .iwindow(g_win), .iwindow_valid(g_valid),
    .owindow_ready(g_ready), .ihold(g_hold), .iflush(g_flush),
    .odata(g_data), .odata_en(g_en), .odata_last(g_last), .obusy(g_busy)
  );

  typedef struct {
    int         e;
    logic [W-1:0] d;
    logic       l;
  } strobe_t;

  strobe_t      cap_q[$];
  strobe_t      gcap_q[$];
  logic [W-1:0] data_at [int];
  int           cyc = 0;
  int           stray_last = 0;
  int           checks = 0;
  int           failures = 0;
  int           exp_edge[$];
  int           exp_idx[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe is logged with the edge number that produced it.
  always @(negedge clk) begin
    data_at[cyc] = data;
    if (en === 1'b1) cap_q.push_back('{e: cyc, d: data, l: last});
    if (g_en === 1'b1) gcap_q.push_back('{e: cyc, d: g_data, l: g_last});
    if (last === 1'b1 && en !== 1'b1) stray_last++;
    if (g_last === 1'b1 && g_en !== 1'b1) stray_last++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: after acceptance at relative edge 0, element k goes out at the first
  // edge not stalled by hold, and a non-last element is followed by gap idle edges.
  function automatic void model_window(input int n, input int gap, input logic [127:0] hmask);
    int e;
    e = 1;
    exp_edge.delete();
    exp_idx.delete();
    for (int k = 0; k < n; k++) begin
      while (e < 127 && hmask[e] === 1'b1) e++;
      exp_edge.push_back(e);
      exp_idx.push_back(k);
      e = e + 1 + gap;
    end
  endfunction

  function automatic logic [N*W-1:0] seq_window(input int base, input int step);
    logic [N*W-1:0] w;
    for (int k = 0; k < N; k++) w[k*W +: W] = W'(base + k*step);
    return w;
  endfunction

  function automatic logic [N*W-1:0] rand_window();
    logic [N*W-1:0] w;
    for (int k = 0; k < N; k++) w[k*W +: W] = W'($urandom);
    return w;
  endfunction

  function automatic logic [127:0] rand_hold(input int span);
    logic [127:0] m;
    m = '0;
    for (int r = 1; r <= span; r++) m[r] = ($urandom_range(0, 3) == 0);
    return m;
  endfunction

  task automatic run_window(input bit use_gap, input logic [N*W-1:0] w,
                            input logic [127:0] hmask, input int ncyc, output int t0);
    if (use_gap) begin
      g_win = w[GN*W-1:0];
      g_valid = 1'b1;
    end else begin
      win = w;
      valid = 1'b1;
    end
    tick();
    t0 = cyc;
    valid = 1'b0;
    g_valid = 1'b0;
    for (int r = 1; r <= ncyc; r++) begin
      if (use_gap) g_hold = hmask[r];
      else hold = hmask[r];
      tick();
    end
    hold = 1'b0;
    g_hold = 1'b0;
  endtask

  task automatic test_reset();
    irst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      win = rand_window();
      valid = 1'($urandom_range(0, 1));
      hold  = 1'($urandom_range(0, 1));
      flush = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({data, en, last, ready, busy} !== '0) begin
        failures++;
        $display("FAIL reset_outputs: got data=%0h en=%0b last=%0b ready=%0b busy=%0b, expected all 0",
                 data, en, last, ready, busy);
      end
      checks++;
      if ({g_data, g_en, g_last, g_ready, g_busy} !== '0) begin
        failures++;
        $display("FAIL reset_outputs_gap: got data=%0h en=%0b last=%0b ready=%0b busy=%0b, expected all 0",
                 g_data, g_en, g_last, g_ready, g_busy);
      end
    end
    irst = 1'b0;
    valid = 1'b0;
    hold = 1'b0;
    flush = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got ready=%0b busy=%0b, expected ready=1 busy=0", ready, busy);
    end
    tick();
  endtask

  task automatic test_single();
    logic [N*W-1:0] w;
    int t0;
    w = seq_window(1, 1);
    cap_q.delete();
    model_window(N, 0, '0);
    run_window(0, w, '0, 12, t0);
    checks++;
    if (cap_q.size() != exp_edge.size()) begin
      failures++;
      $display("FAIL single_count: got %0d strobes, expected %0d", cap_q.size(), exp_edge.size());
    end
    for (int i = 0; i < exp_edge.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i].e - t0 != exp_edge[i] || cap_q[i].d !== w[exp_idx[i]*W +: W] ||
          cap_q[i].l !== (exp_idx[i] == N-1)) begin
        failures++;
        $display("FAIL single_strobe%0d: got edge+%0d data=%0d last=%0b, expected edge+%0d data=%0d last=%0b",
                 i, cap_q[i].e - t0, cap_q[i].d, cap_q[i].l, exp_edge[i], w[exp_idx[i]*W +: W],
                 exp_idx[i] == N-1);
      end
    end
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle_after: got ready=%0b busy=%0b, expected ready=1 busy=0", ready, busy);
    end
  endtask

  task automatic test_hold();
    logic [N*W-1:0] w;
    logic [127:0] m;
    int t0;
    w = seq_window(1, 1);
    m = '0;
    for (int r = 5; r <= 8; r++) m[r] = 1'b1;
    cap_q.delete();
    model_window(N, 0, m);
    run_window(0, w, m, 16, t0);
    checks++;
    if (cap_q.size() != exp_edge.size()) begin
      failures++;
      $display("FAIL hold_count: got %0d strobes, expected %0d", cap_q.size(), exp_edge.size());
    end
    for (int i = 0; i < exp_edge.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i].e - t0 != exp_edge[i] || cap_q[i].d !== w[exp_idx[i]*W +: W] ||
          cap_q[i].l !== (exp_idx[i] == N-1)) begin
        failures++;
        $display("FAIL hold_strobe%0d: got edge+%0d data=%0d last=%0b, expected edge+%0d data=%0d",
                 i, cap_q[i].e - t0, cap_q[i].d, cap_q[i].l, exp_edge[i], w[exp_idx[i]*W +: W]);
      end
    end
    for (int r = 5; r <= 8; r++) begin
      checks++;
      if (data_at[t0 + r] !== 8'd4) begin
        failures++;
        $display("FAIL hold_data_edge%0d: got odata=%0d, expected 4", r, data_at[t0 + r]);
      end
    end
  endtask

  task automatic test_random();
    logic [N*W-1:0] w;
    logic [127:0] m;
    int t0;
    for (int it = 0; it < 4; it++) begin
      w = rand_window();
      m = rand_hold(20);
      cap_q.delete();
      model_window(N, 0, m);
      run_window(0, w, m, 40, t0);
      checks++;
      if (cap_q.size() != exp_edge.size()) begin
        failures++;
        $display("FAIL random%0d_count: got %0d strobes, expected %0d", it, cap_q.size(), exp_edge.size());
      end
      for (int i = 0; i < exp_edge.size() && i < cap_q.size(); i++) begin
        checks++;
        if (cap_q[i].e - t0 != exp_edge[i] || cap_q[i].d !== w[exp_idx[i]*W +: W] ||
            cap_q[i].l !== (exp_idx[i] == N-1)) begin
          failures++;
          $display("FAIL random%0d_strobe%0d: got edge+%0d data=%0h last=%0b, expected edge+%0d data=%0h",
                   it, i, cap_q[i].e - t0, cap_q[i].d, cap_q[i].l, exp_edge[i], w[exp_idx[i]*W +: W]);
        end
      end
    end
  endtask

  task automatic test_gap();
    logic [N*W-1:0] w;
    logic [127:0] m;
    int t0;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        w = seq_window(10, 10);
        m = '0;
      end else begin
        w = rand_window();
        m = rand_hold(12);
      end
      gcap_q.delete();
      model_window(GN, GG, m);
      run_window(1, w, m, 24, t0);
      checks++;
      if (gcap_q.size() != exp_edge.size()) begin
        failures++;
        $display("FAIL gap%0d_count: got %0d strobes, expected %0d", it, gcap_q.size(), exp_edge.size());
      end
      for (int i = 0; i < exp_edge.size() && i < gcap_q.size(); i++) begin
        checks++;
        if (gcap_q[i].e - t0 != exp_edge[i] || gcap_q[i].d !== w[exp_idx[i]*W +: W] ||
            gcap_q[i].l !== (exp_idx[i] == GN-1)) begin
          failures++;
          $display("FAIL gap%0d_strobe%0d: got edge+%0d data=%0d last=%0b, expected edge+%0d data=%0d",
                   it, i, gcap_q[i].e - t0, gcap_q[i].d, gcap_q[i].l, exp_edge[i], w[exp_idx[i]*W +: W]);
        end
      end
      if (it == 0 && gcap_q.size() == 3) begin
        checks++;
        if (gcap_q[2].e - gcap_q[0].e != 6) begin
          failures++;
          $display("FAIL gap_span: got %0d cycles first to last strobe, expected 6",
                   gcap_q[2].e - gcap_q[0].e);
        end
      end
      checks++;
      if (g_ready !== 1'b1 || g_busy !== 1'b0) begin
        failures++;
        $display("FAIL gap%0d_idle_after: got ready=%0b busy=%0b, expected 1/0", it, g_ready, g_busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N*W-1:0] wa, wb;
    logic take;
    int t0, e_exp, lasts;
    wa = seq_window(1, 1);
    wb = seq_window(11, 1);
    cap_q.delete();
    model_window(N, 0, '0);
    win = wa;
    valid = 1'b1;
    tick();
    t0 = cyc;
    win = wb;
    for (int r = 1; r <= 24; r++) begin
      take = valid && ready;
      tick();
      if (take) valid = 1'b0;
      if (last === 1'b1) begin
        checks++;
        if (ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_ready_with_last: got ready=%0b at edge+%0d, expected 1", ready, r);
        end
      end
    end
    valid = 1'b0;
    checks++;
    if (cap_q.size() != 2*N) begin
      failures++;
      $display("FAIL b2b_count: got %0d strobes, expected %0d", cap_q.size(), 2*N);
    end
    lasts = 0;
    for (int i = 0; i < 2*N && i < cap_q.size(); i++) begin
      e_exp = (i < N) ? exp_edge[i] : exp_edge[i-N] + exp_edge[N-1] + 1;
      if (cap_q[i].l === 1'b1) lasts++;
      checks++;
      if (cap_q[i].e - t0 != e_exp ||
          cap_q[i].d !== ((i < N) ? wa[(i%N)*W +: W] : wb[(i%N)*W +: W])) begin
        failures++;
        $display("FAIL b2b_strobe%0d: got edge+%0d data=%0d, expected edge+%0d data=%0d",
                 i, cap_q[i].e - t0, cap_q[i].d, e_exp, (i < N) ? wa[(i%N)*W +: W] : wb[(i%N)*W +: W]);
      end
    end
    checks++;
    if (lasts != 2) begin
      failures++;
      $display("FAIL b2b_last_count: got %0d, expected 2", lasts);
    end
  endtask

  task automatic test_flush(input bit use_rst);
    logic [N*W-1:0] w;
    int t0;
    w = rand_window();
    cap_q.delete();
    win = w;
    valid = 1'b1;
    tick();
    t0 = cyc;
    valid = 1'b0;
    for (int r = 1; r <= 5; r++) tick();
    checks++;
    if (en !== 1'b1 || data !== w[4*W +: W]) begin
      failures++;
      $display("FAIL abort%0d_pre: got en=%0b data=%0h, expected en=1 data=%0h", use_rst, en, data, w[4*W +: W]);
    end
    if (use_rst) irst = 1'b1;
    else flush = 1'b1;
    win = rand_window();
    valid = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL abort%0d_ready_during: got ready=%0b, expected 0", use_rst, ready);
    end
    tick();
    checks++;
    if (en !== 1'b0 || last !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort%0d_after: got en=%0b last=%0b busy=%0b, expected 0/0/0", use_rst, en, last, busy);
    end
    irst = 1'b0;
    flush = 1'b0;
    valid = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL abort%0d_ready_next: got ready=%0b, expected 1", use_rst, ready);
    end
    for (int r = 0; r < 12; r++) tick();
    checks++;
    if (cap_q.size() != 5) begin
      failures++;
      $display("FAIL abort%0d_count: got %0d strobes, expected 5", use_rst, cap_q.size());
    end
    for (int i = 0; i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i].l !== 1'b0 || cap_q[i].d !== w[i*W +: W] || cap_q[i].e - t0 != i + 1) begin
        failures++;
        $display("FAIL abort%0d_strobe%0d: got edge+%0d data=%0h last=%0b, expected edge+%0d data=%0h last=0",
                 use_rst, i, cap_q[i].e - t0, cap_q[i].d, cap_q[i].l, i + 1, (i < N) ? w[i*W +: W] : '0);
      end
    end
  endtask

  task automatic test_after_abort();
    logic [N*W-1:0] w;
    int t0;
    w = rand_window();
    cap_q.delete();
    model_window(N, 0, '0);
    run_window(0, w, '0, 12, t0);
    checks++;
    if (cap_q.size() != N) begin
      failures++;
      $display("FAIL recover_count: got %0d strobes, expected %0d", cap_q.size(), N);
    end
    for (int i = 0; i < N && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i].e - t0 != exp_edge[i] || cap_q[i].d !== w[i*W +: W] || cap_q[i].l !== (i == N-1)) begin
        failures++;
        $display("FAIL recover_strobe%0d: got edge+%0d data=%0h last=%0b, expected edge+%0d data=%0h",
                 i, cap_q[i].e - t0, cap_q[i].d, cap_q[i].l, exp_edge[i], w[i*W +: W]);
      end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (stray_last != 0) begin
      failures++;
      $display("FAIL last_without_en: got %0d occurrences, expected 0", stray_last);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_random();
    test_gap();
    test_back_to_back();
    test_flush(1'b0);
    test_flush(1'b1);
    test_after_abort();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
